// File: rtl/sram_port_ctrl_pkg.sv
// Shared constants for the SRAM port controller: FSM state encoding and default widths.
package sram_port_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_WORD_DEPTH = 256;
    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR      = ST_WR,
        RD_ADDR = ST_RD_ADDR,
        RD_DATA = ST_RD_DATA,
        RD_RESP = ST_RD_RESP
    } state_t;

endpackage

// File: rtl/sync_sram.sv
// Single-port synchronous SRAM model: active-low write enable, registered read data.
module sync_sram
    import sram_port_ctrl_pkg::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int word_width = DEF_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_n,
    input  logic [addr_width-1:0] addr,
    input  logic [word_width-1:0] din,
    output logic [word_width-1:0] dout
);

    logic [word_width-1:0] mem [2**addr_width];

    // NOTE: the array has no reset; a macro cannot clear its contents and a reset here would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (!we_n) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller sequencing a sync SRAM for single-word writes and burst reads.
module sram_port_ctrl
    import sram_port_ctrl_pkg::*;
#(
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int word_depth = DEF_WORD_DEPTH,
    parameter int word_width = DEF_WORD_WIDTH,
    parameter int len_width  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [addr_width-1:0] req_addr,
    input  logic [word_width-1:0] req_wdata,
    input  logic [len_width-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [word_width-1:0] rsp_rdata,
    output logic                  rsp_last,
    output logic                  busy,
    output logic [addr_width-1:0] sram_addr,
    output logic [word_width-1:0] sram_din,
    output logic                  sram_we_n,
    input  logic [word_width-1:0] sram_dout
);

    localparam logic [addr_width-1:0] ADDR_MAX = addr_width'(word_depth - 1);

    state_t               state;
    logic [len_width-1:0] remaining;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            sram_addr <= '0;
            sram_din  <= '0;
            sram_we_n <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sram_addr <= req_addr;
                        if (req_write) begin
                            sram_din  <= req_wdata;
                            sram_we_n <= 1'b0;
                            state     <= WR;
                        end else begin
                            remaining <= req_len;
                            state     <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    sram_we_n <= 1'b1;
                    state     <= IDLE;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    rsp_rdata <= sram_dout;
                    rsp_valid <= 1'b1;
                    rsp_last  <= (remaining == '0);
                    state     <= RD_RESP;
                end
                RD_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (remaining == '0) begin
                            state <= IDLE;
                        end else begin
                            // Wrap explicitly so a non-power-of-two depth still stays in range.
                            sram_addr <= (sram_addr == ADDR_MAX) ? '0 : sram_addr + 1'b1;
                            remaining <= remaining - 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed self-checking bench for sram_port_ctrl driving a sync_sram model.
module tb_sram_port_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic [3:0] req_len;
    logic       rsp_valid, rsp_ready, rsp_last, busy;
    logic [7:0] rsp_rdata;
    logic [7:0] sram_addr, sram_din, sram_dout;
    logic       sram_we_n;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] rd_data [16];
    logic       rd_last [16];
    int         rd_lat;

    int   we_viol   = 0;
    int   we_pulses = 0;
    logic we_prev_low = 1'b0;

    always #5 clk = ~clk;

    sram_port_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .busy(busy),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_we_n(sram_we_n),
        .sram_dout(sram_dout)
    );

    sync_sram u_sram (
        .clk(clk), .we_n(sram_we_n), .addr(sram_addr), .din(sram_din), .dout(sram_dout)
    );

    // Write-enable pulses must be single-cycle; sampled mid-cycle to stay clear of the edge.
    always @(negedge clk) begin
        if (!sram_we_n && we_prev_low) we_viol++;
        if (!sram_we_n && !we_prev_low) we_pulses++;
        we_prev_low = !sram_we_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (!req_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        if (!req_ready) check("idle_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        wait_idle();
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        tick();
        req_valid = 1'b0;
        check("wr_we_low", sram_we_n, 0);
        check("wr_addr", sram_addr, addr);
        check("wr_din", sram_din, data);
        tick();
        check("wr_we_high", sram_we_n, 1);
        check("wr_back_idle", req_ready, 1);
    endtask

    // Captures beats into rd_data/rd_last; stall0 > 0 holds rsp_ready low on beat 0 for that many cycles.
    task automatic read_burst(input logic [7:0] addr, input logic [3:0] len, input int stall0);
        int         cnt;
        logic [7:0] hold_data, hold_addr;
        wait_idle();
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
        rsp_ready = (stall0 == 0);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            cnt = 1;
            while (!rsp_valid && cnt < 20) begin
                tick();
                cnt++;
            end
            if (!rsp_valid) begin
                check("rd_timeout", 0, 1);
                rsp_ready = 1'b1;
                return;
            end
            if (b == 0) rd_lat = cnt;
            if (b == 0 && stall0 > 0) begin
                hold_data = rsp_rdata;
                hold_addr = sram_addr;
                for (int s = 1; s < stall0; s++) begin
                    tick();
                    check("bp_valid", rsp_valid, 1);
                    check("bp_rdata", rsp_rdata, hold_data);
                    check("bp_addr", sram_addr, hold_addr);
                end
                rsp_ready = 1'b1;
            end
            rd_data[b] = rsp_rdata;
            rd_last[b] = rsp_last;
            tick();
        end
    endtask

    initial begin
        int nb, busy_cycles, spurious, pulses0;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
        #23;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single write then single read.
        do_write(8'h10, 8'hA5);
        read_burst(8'h10, 4'd0, 0);
        check("single_lat", rd_lat, 3);
        check("single_data", rd_data[0], 8'hA5);
        check("single_last", rd_last[0], 1);
        check("single_idle", req_ready, 1);

        // Burst across the address wrap.
        do_write(8'hFE, 8'h11);
        do_write(8'hFF, 8'h22);
        do_write(8'h00, 8'h33);
        do_write(8'h01, 8'h44);
        read_burst(8'hFE, 4'd3, 0);
        check("wrap_b0", rd_data[0], 8'h11);
        check("wrap_b1", rd_data[1], 8'h22);
        check("wrap_b2", rd_data[2], 8'h33);
        check("wrap_b3", rd_data[3], 8'h44);
        check("wrap_l0", rd_last[0], 0);
        check("wrap_l1", rd_last[1], 0);
        check("wrap_l2", rd_last[2], 0);
        check("wrap_l3", rd_last[3], 1);

        // Backpressure on beat 0 of a two-word read.
        read_burst(8'hFF, 4'd1, 5);
        check("bp_b0", rd_data[0], 8'h22);
        check("bp_b1", rd_data[1], 8'h33);
        check("bp_l0", rd_last[0], 0);
        check("bp_l1", rd_last[1], 1);

        // Write held pending while a burst is in flight.
        do_write(8'h11, 8'h77);
        wait_idle();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_len = 4'd1; rsp_ready = 1'b1;
        tick();
        req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h5A;
        nb = 0; busy_cycles = 0;
        for (int c = 0; c < 30 && !req_ready; c++) begin
            busy_cycles++;
            if (rsp_valid && nb < 16) begin
                rd_data[nb] = rsp_rdata;
                rd_last[nb] = rsp_last;
                nb++;
            end
            tick();
        end
        check("gate_busy_cycles", busy_cycles, 6);
        check("gate_beats", nb, 2);
        check("gate_b0", rd_data[0], 8'hA5);
        check("gate_b1", rd_data[1], 8'h77);
        check("gate_l1", rd_last[1], 1);
        tick();
        req_valid = 1'b0;
        check("gate_we_low", sram_we_n, 0);
        check("gate_wr_addr", sram_addr, 8'h20);
        tick();
        read_burst(8'h20, 4'd0, 0);
        check("gate_mem", rd_data[0], 8'h5A);

        // Asynchronous reset during RD_DATA of an 8-word read.
        wait_idle();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30; req_len = 4'd7;
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_req_ready", req_ready, 1);
        check("arst_addr", sram_addr, 0);
        check("arst_din", sram_din, 0);
        check("arst_we_n", sram_we_n, 1);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rdata", rsp_rdata, 0);
        check("arst_last", rsp_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid || busy || !req_ready) spurious++;
        end
        check("post_rst_quiet", spurious, 0);

        // Back-to-back writes and readback.
        pulses0 = we_pulses;
        for (int i = 0; i < 4; i++) do_write(8'(i), 8'(8'h10 + i));
        tick();
        check("b2b_pulses", we_pulses - pulses0, 4);
        read_burst(8'h00, 4'd3, 0);
        for (int i = 0; i < 4; i++) check("b2b_mem", rd_data[i], 8'(8'h10 + i));
        check("b2b_gap_last", rd_last[3], 1);

        check("we_pulse_width", we_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
